window_gen: RTL and testbench

- Upstream neighbour of the convolver `controlpath`/datapath.
- Accepts a raster-order pixel stream (valid/ready) for one WIDTH x HEIGHT image at a time.
- Buffers KERNEL_SIZE-1 rows and emits each full KERNEL_SIZE x KERNEL_SIZE window with a valid/ready handshake.
- The convolver consumes one window per handshake; only "valid"-mode windows are produced, (HEIGHT-K+1)*(WIDTH-K+1) per frame.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/window_gen_line_buffer.sv | 53 +++++
 rtl/window_gen.sv | 169 ++++++++++++++++
 tb/tb_window_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolver front end (window_gen) and the
// convolver control/datapath.
//   - default geometry: kernel edge, image width/height, pixel width
//   - window packing index helper
//   - two-state FSM encoding used by the window generator and control FSM
// No ports (package).
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int KERNEL_SIZE_DEF = 5;
    localparam int WIDTH_DEF       = 28;
    localparam int HEIGHT_DEF      = 28;
    localparam int DATA_W_DEF      = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } win_state_t;

    // Bit offset of window element (r, c) in a packed K x K window.
    function automatic int win_index(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image-row delay. dout presents the din that was written DEPTH enabled
// cycles earlier, i.e. the pixel directly above the one currently on din.
// Storage is a circular RAM of DEPTH-1 words with a registered read; the read
// register supplies the last stage of delay.
// Ports:
//   clk   in   clock
//   reset in   synchronous active-high reset (pointer only)
//   en    in   advance the delay line by one pixel
//   din   in   DATA_W pixel entering the delay
//   dout  out  DATA_W pixel delayed by DEPTH enables
// -----------------------------------------------------------------------------
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH  = WIDTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int MEM_D = DEPTH - 1;
    localparam int PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic [DATA_W-1:0] r_mem [MEM_D];
    logic [PTR_W-1:0]  r_ptr;
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == PTR_W'(MEM_D - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    // Read-before-write on the same address: the word read out is the one
    // being overwritten, which is exactly MEM_D enables old.
    always_ff @(posedge clk) begin
        if (en) begin
            r_dout       <= r_mem[r_ptr];
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/window_gen.sv
// -----------------------------------------------------------------------------
// window_gen
// Turns a raster-order pixel stream into K x K "valid"-mode windows, one per
// handshake, (HEIGHT-K+1)*(WIDTH-K+1) windows per frame.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   pix_in     in   DATA_W input pixel
//   pix_valid  in   pix_in valid
//   pix_ready  out  pixel accepted this cycle when pix_valid is high
//   win_out    out  K*K*DATA_W window, element (r,c) at (r*K+c)*DATA_W,
//                   r=0 oldest row, c=0 leftmost column
//   win_valid  out  win_out holds an unconsumed window
//   win_ready  in   downstream consumes win_out
//   frame_done out  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_gen
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DATA_W-1:0]                      pix_in,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0] win_out,
    output logic                                   win_valid,
    input  logic                                   win_ready,
    output logic                                   frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int WB = K * K * DATA_W;
    localparam int CW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    win_state_t        r_state;
    win_state_t        w_state_next;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              w_acc;
    logic              w_emit;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_last;
    logic [DATA_W-1:0] w_tap      [K-1];
    logic [DATA_W-1:0] r_win      [K][K];
    logic [DATA_W-1:0] w_win_next [K][K];
    logic [WB-1:0]     w_win_packed;
    logic [WB-1:0]     r_win_out;
    logic              r_win_valid;
    logic              r_frame_done;

    // A single output register: new pixels may enter whenever that register
    // is empty or being drained this cycle.
    assign pix_ready    = !r_win_valid || win_ready;
    assign w_acc        = pix_valid && pix_ready;
    assign w_col_last   = (r_col == CW'(WIDTH - 1));
    assign w_row_last   = (r_row == RW'(HEIGHT - 1));
    assign w_frame_last = w_col_last && w_row_last;

    // Tap gi delays the stream by gi+1 rows.
    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [DATA_W-1:0] w_din;
            if (gi == 0) begin : g_first
                assign w_din = pix_in;
            end else begin : g_chain
                assign w_din = w_tap[gi-1];
            end
            line_buffer #(
                .DEPTH  (WIDTH),
                .DATA_W (DATA_W)
            ) u_lb (
                .clk   (clk),
                .reset (reset),
                .en    (w_acc),
                .din   (w_din),
                .dout  (w_tap[gi])
            );
        end
    endgenerate

    // Shift left one column; the new right column is the oldest tap at the top
    // down to the incoming pixel at the bottom.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_row
            for (genvar gj = 0; gj < K; gj++) begin : g_col
                if (gj < K - 1) begin : g_shift
                    assign w_win_next[gi][gj] = r_win[gi][gj+1];
                end else if (gi == K - 1) begin : g_newest
                    assign w_win_next[gi][gj] = pix_in;
                end else begin : g_tap
                    assign w_win_next[gi][gj] = w_tap[K-2-gi];
                end
                assign w_win_packed[win_index(gi, gj, K, DATA_W) +: DATA_W] = w_win_next[gi][gj];
            end
        end
    endgenerate

    // FILL covers the first K-1 rows, so neither stale line-buffer data from a
    // previous frame nor a partial window ever reaches the output.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_acc && w_col_last && (r_row == RW'(K - 2))) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // col < K-1 would mix columns from the previous row.
                w_emit = w_acc && (r_col >= CW'(K - 1));
                if (w_acc && w_frame_last) begin
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_win_out    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_acc && w_frame_last;
            if (w_acc) begin
                r_win <= w_win_next;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // An emit overrides a consume so back-to-back windows keep
            // win_valid high.
            if (w_emit) begin
                r_win_out   <= w_win_packed;
                r_win_valid <= 1'b1;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_out    = r_win_out;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_gen.sv
// -----------------------------------------------------------------------------
// tb_window_gen
// Scoreboard bench for window_gen: expected windows are computed from pixel
// coordinates when a pixel is accepted and queued; a monitor pops and compares
// on each window handshake.
// -----------------------------------------------------------------------------
module tb_window_gen;
    import conv_pkg::*;

    localparam int K  = 5;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int DW = 8;
    localparam int WB = K * K * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [WB-1:0] win_out;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic          frame_done;

    window_gen #(
        .KERNEL_SIZE (K),
        .WIDTH       (W),
        .HEIGHT      (H),
        .DATA_W      (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    int  m_row = 0, m_col = 0, m_frame = 0, m_acc = 0, last_acc_cyc = 0;
    bit  fd_exp = 1'b0;
    logic [WB-1:0] exp_q[$];

    // stimulus controls
    bit run = 1'b0;
    int n_frames = 0, pv_pct = 100, wr_pct = 100;
    bit bp_arm = 1'b0, bp_started = 1'b0;
    int hold = 0;

    // monitor observations
    int n_win = 0, fd_count = 0, first_acc = -1, first_lat = -1;
    int f_e00 = -1, f_e04 = -1, f_e40 = -1, f_e44 = -1;
    int w1_e00 = -1, w1_e44 = -1, w24_e00 = -1, w24_e44 = -1, w576_e00 = -1;

    function automatic logic [DW-1:0] pval(input int f, input int r, input int c);
        logic [DW-1:0] v;
        v = 8'((r * W + c + 100 * f) % 256);
        return v;
    endfunction

    // Window whose bottom-right pixel is (r, c) of frame f.
    function automatic logic [WB-1:0] ref_win(input int f, input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i * K + j) * DW +: DW] = pval(f, r - K + 1 + i, c - K + 1 + j);
        return w;
    endfunction

    function automatic int elem(input logic [WB-1:0] w, input int r, input int c);
        return int'(w[(r * K + c) * DW +: DW]);
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // driver
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_arm && win_valid) begin
            bp_arm     = 1'b0;
            hold       = 10;
            bp_started = 1'b1;
        end
        pix_valid = run && (m_frame < n_frames) && (int'($urandom_range(99)) < pv_pct);
        pix_in    = pval(m_frame, m_row, m_col);
        if (hold > 0) begin
            win_ready = 1'b0;
            hold--;
        end else begin
            win_ready = run && (int'($urandom_range(99)) < wr_pct);
        end
    end

    // accept tracker: pushes expected windows, checks frame_done timing
    initial forever begin
        bit acc;
        @(negedge clk);
        if (!reset) begin
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL frame_done: got %0b expected %0b at cycle %0d", frame_done, fd_exp, cyc);
            end
            if (frame_done) fd_count++;
            acc    = pix_valid && pix_ready;
            fd_exp = acc && (m_row == H - 1) && (m_col == W - 1);
            if (acc) begin
                m_acc++;
                last_acc_cyc = cyc;
                if (m_row >= K - 1 && m_col >= K - 1)
                    exp_q.push_back(ref_win(m_frame, m_row, m_col));
                if (m_col == W - 1) begin
                    m_col = 0;
                    if (m_row == H - 1) begin
                        m_row = 0;
                        m_frame++;
                    end else begin
                        m_row++;
                    end
                end else begin
                    m_col++;
                end
            end
        end
    end

    // monitor: pops and compares on each window handshake
    initial forever begin
        logic [WB-1:0] exp_w;
        @(posedge clk);
        #3;
        if (!reset && win_valid) begin
            if (first_acc < 0) begin
                first_acc = m_acc;
                first_lat = cyc - last_acc_cyc;
            end
            if (win_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL win_unexpected: window %0d got %h expected none", n_win, win_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (win_out !== exp_w) begin
                        errors++;
                        $display("FAIL win_data: window %0d got %h expected %h", n_win, win_out, exp_w);
                    end
                end
                if (n_win == 0) begin
                    f_e00 = elem(win_out, 0, 0); f_e04 = elem(win_out, 0, 4);
                    f_e40 = elem(win_out, 4, 0); f_e44 = elem(win_out, 4, 4);
                end
                if (n_win == 1)   begin w1_e00  = elem(win_out, 0, 0); w1_e44  = elem(win_out, 4, 4); end
                if (n_win == 24)  begin w24_e00 = elem(win_out, 0, 0); w24_e44 = elem(win_out, 4, 4); end
                if (n_win == 576) w576_e00 = elem(win_out, 0, 0);
                n_win++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1; run = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
        hold = 0; bp_arm = 1'b0; bp_started = 1'b0;
        exp_q.delete();
        m_row = 0; m_col = 0; m_frame = 0; m_acc = 0; fd_exp = 1'b0;
        n_win = 0; fd_count = 0; first_acc = -1; first_lat = -1;
        @(posedge clk);
        #2;
        check_int("reset_win_valid", int'(win_valid), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        check_int("reset_pix_ready", int'(pix_ready), 1);
        checks++;
        if (win_out !== '0) begin
            errors++;
            $display("FAIL reset_win_out: got %h expected 0", win_out);
        end
        reset = 1'b0;
    endtask

    task automatic run_frames(input int nf, input int pv, input int wr, input bit bp);
        int budget;
        int bp_checked;
        logic [WB-1:0] held;
        held = ref_win(0, K - 1, K - 1);
        n_frames = nf; pv_pct = pv; wr_pct = wr; bp_arm = bp; run = 1'b1;
        budget = 0; bp_checked = 0;
        while (!(m_frame >= nf && exp_q.size() == 0 && !win_valid) && budget < 20000) begin
            @(posedge clk);
            #2;
            budget++;
            if (bp_started && bp_checked < 10) begin
                bp_checked++;
                check_int("bp_pix_ready", int'(pix_ready), 0);
                checks++;
                if (win_out !== held) begin
                    errors++;
                    $display("FAIL bp_win_hold: cycle %0d got %h expected %h", bp_checked, win_out, held);
                end
            end
        end
        if (budget >= 20000) begin
            errors++;
            $display("FAIL timeout: frames=%0d windows=%0d queued=%0d", m_frame, n_win, exp_q.size());
        end
        checks++;
        run = 1'b0;
        if (bp) check_int("bp_cycles_checked", bp_checked, 10);
    endtask

    initial begin
        int budget;
        do_reset();

        // continuous streaming
        run_frames(1, 100, 100, 1'b0);
        check_int("stream_windows", n_win, 576);
        check_int("stream_frame_done", fd_count, 1);
        check_int("first_win_pixels", first_acc, 117);
        check_int("first_win_latency", first_lat, 1);
        check_int("first_e00", f_e00, 0);
        check_int("first_e04", f_e04, 4);
        check_int("first_e40", f_e40, 112);
        check_int("first_e44", f_e44, 116);
        check_int("row_edge_e00", w24_e00, 28);
        check_int("row_edge_e44", w24_e44, 144);

        // backpressure after the first window
        do_reset();
        run_frames(1, 100, 100, 1'b1);
        check_int("bp_windows", n_win, 576);
        check_int("bp_next_e00", w1_e00, 1);
        check_int("bp_next_e44", w1_e44, 117);

        // random valid/ready
        do_reset();
        run_frames(1, 50, 50, 1'b0);
        check_int("rand_windows", n_win, 576);
        check_int("rand_frame_done", fd_count, 1);

        // reset mid-frame after 50 accepted pixels
        do_reset();
        n_frames = 1; pv_pct = 100; wr_pct = 100; run = 1'b1;
        budget = 0;
        while (m_acc < 50 && budget < 1000) begin
            @(posedge clk);
            #2;
            budget++;
        end
        check_int("midreset_reached50", int'(m_acc >= 50), 1);
        do_reset();
        run_frames(1, 100, 100, 1'b0);
        check_int("midreset_first_pixels", first_acc, 117);
        check_int("midreset_e00", f_e00, 0);
        check_int("midreset_e44", f_e44, 116);
        check_int("midreset_windows", n_win, 576);

        // two back-to-back frames
        do_reset();
        run_frames(2, 100, 100, 1'b0);
        check_int("b2b_frame_done", fd_count, 2);
        check_int("b2b_windows", n_win, 1152);
        check_int("b2b_frame2_e00", w576_e00, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
